lsu_mem_ctrl: RTL and testbench

Load/store unit sitting directly downstream of the main controller in the single-cycle RV32I core. It consumes the controller's `load` and `mem_write` qualifiers together with the ALU address, rs2 data and funct3. It runs a request/acknowledge transaction on the data-memory port, generating byte enables and aligning store data. It returns sign/zero-extended load data to writeback and stalls the core while the access is outstanding.

---
 rtl/rv_core_pkg.sv | 19 +
 rtl/lsu_mem_ctrl_if.sv | 25 ++
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/rv_core_pkg.sv
// Shared RV32I core definitions: funct3 encodings for memory ops and LSU state type.
package rv_core_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory request/acknowledge port between the LSU (master) and memory (slave).
interface lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half from a read word and sign- or zero-extends it.
module lsu_load_align
  import rv_core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: checks legality, builds byte lanes, runs one memory transaction
// per access and stalls the core until the result is ready.
module lsu_mem_ctrl
  import rv_core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              access_err,
  lsu_mem_if.master         mem
);

  lsu_state_t        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              ld_valid_q, ld_valid_d;

  logic              access;
  logic              legal;
  logic [3:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] ext_data;

  lsu_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata  (mem.mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  // A store wins when load and mem_write are both raised, so legality uses store rules.
  always_comb begin
    access = load | mem_write;
    case (funct3)
      F3_LB:   legal = 1'b1;
      F3_LH:   legal = ~addr[0];
      F3_LW:   legal = (addr[1:0] == 2'b00);
      F3_LBU:  legal = ~mem_write;
      F3_LHU:  legal = ~mem_write & ~addr[0];
      default: legal = 1'b0;
    endcase

    lane_be    = 4'b1111;
    lane_wdata = '0;
    if (mem_write) begin
      case (funct3)
        F3_SB: begin
          lane_be    = 4'b0001 << addr[1:0];
          lane_wdata = {4{wdata[7:0]}};
        end
        F3_SH: begin
          lane_be    = 4'b0011 << {addr[1], 1'b0};
          lane_wdata = {2{wdata[15:0]}};
        end
        default: lane_wdata = wdata;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    f3_d       = f3_q;
    off_d      = off_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    stall      = 1'b0;
    access_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (access && legal) begin
          stall   = 1'b1;
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = {addr[ADDR_W-1:2], 2'b00};
          wdata_d = lane_wdata;
          be_d    = lane_be;
          f3_d    = funct3;
          off_d   = addr[1:0];
        end else if (access) begin
          access_err = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            ld_data_d  = ext_data;
            ld_valid_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      stall      = 1'b0;
      access_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      ld_data_q  <= '0;
      ld_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_be    = be_q;
  assign ld_data       = ld_data_q;
  assign ld_valid      = ld_valid_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl; expected load results go through a scoreboard queue.
module tb_lsu_mem_ctrl;
  import rv_core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        access_err;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] sb_q[$];

  lsu_mem_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .access_err (access_err),
    .mem        (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One legal access: issue, hold through waits, ack, then check DONE and the idle cycle after.
  task automatic applyStimulus(input string tag, input logic ld, input logic st,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int waits,
                               input logic [31:0] rd, input logic [31:0] exp_addr,
                               input logic [3:0] exp_be, input logic [31:0] exp_wd,
                               input logic [31:0] exp_ld);
    int  req_cycles;
    logic is_load;
    is_load = ld && !st;
    @(negedge clk);
    load = ld; mem_write = st; funct3 = f3; addr = a; wdata = wd;
    if (is_load) sb_q.push_back(exp_ld);
    #1;
    checkOutput({tag, ".issue_stall"}, {31'd0, stall}, 32'd1);
    checkOutput({tag, ".issue_req"}, {31'd0, mif.mem_req}, 32'd0);
    req_cycles = 0;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      mif.mem_ack   = (i == waits);
      mif.mem_rdata = (i == waits) ? rd : $urandom;
      #1;
      if (mif.mem_req) req_cycles++;
      checkOutput({tag, ".req_stall"}, {31'd0, stall}, 32'd1);
      checkOutput({tag, ".mem_addr"}, mif.mem_addr, exp_addr);
      checkOutput({tag, ".mem_be"}, {28'd0, mif.mem_be}, {28'd0, exp_be});
      checkOutput({tag, ".mem_we"}, {31'd0, mif.mem_we}, {31'd0, st});
      if (st) checkOutput({tag, ".mem_wdata"}, mif.mem_wdata, exp_wd);
    end
    @(negedge clk);
    mif.mem_ack = 1'b0;
    #1;
    checkOutput({tag, ".req_cycles"}, req_cycles, waits + 1);
    checkOutput({tag, ".done_req"}, {31'd0, mif.mem_req}, 32'd0);
    checkOutput({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, ".ld_valid"}, {31'd0, ld_valid}, {31'd0, is_load});
    if (ld_valid) begin
      if (sb_q.size() == 0) checkOutput({tag, ".sb_underflow"}, 32'd1, 32'd0);
      else checkOutput({tag, ".ld_data"}, ld_data, sb_q.pop_front());
    end
    load = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    #1;
    checkOutput({tag, ".ld_valid_pulse"}, {31'd0, ld_valid}, 32'd0);
  endtask

  task automatic applyIllegal(input string tag, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    load = ld; mem_write = st; funct3 = f3; addr = a;
    #1;
    checkOutput({tag, ".err"}, {31'd0, access_err}, 32'd1);
    checkOutput({tag, ".stall"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, ".req"}, {31'd0, mif.mem_req}, 32'd0);
    @(negedge clk);
    load = 1'b0; mem_write = 1'b0;
    #1;
    checkOutput({tag, ".err_pulse"}, {31'd0, access_err}, 32'd0);
    checkOutput({tag, ".req_after"}, {31'd0, mif.mem_req}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; mem_write = 1'b0; funct3 = F3_LW;
    addr = 32'h100; wdata = 32'h0;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;

    // Reset state, with a load held so stall must be forced low.
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst.stall", {31'd0, stall}, 32'd0);
    checkOutput("rst.access_err", {31'd0, access_err}, 32'd0);
    checkOutput("rst.mem_req", {31'd0, mif.mem_req}, 32'd0);
    checkOutput("rst.mem_we", {31'd0, mif.mem_we}, 32'd0);
    checkOutput("rst.mem_be", {28'd0, mif.mem_be}, 32'd0);
    checkOutput("rst.mem_addr", mif.mem_addr, 32'd0);
    checkOutput("rst.mem_wdata", mif.mem_wdata, 32'd0);
    checkOutput("rst.ld_data", ld_data, 32'd0);
    checkOutput("rst.ld_valid", {31'd0, ld_valid}, 32'd0);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("lw_aligned", 1, 0, F3_LW,  32'h100, 32'h0, 0, 32'hDEADBEEF,
                  32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    applyStimulus("lb_sign",    1, 0, F3_LB,  32'h103, 32'h0, 0, 32'h80FF1234,
                  32'h100, 4'b1111, 32'h0, 32'hFFFFFF80);
    applyStimulus("lbu_zero",   1, 0, F3_LBU, 32'h103, 32'h0, 0, 32'h80FF1234,
                  32'h100, 4'b1111, 32'h0, 32'h00000080);
    applyStimulus("lh_sign",    1, 0, F3_LH,  32'h102, 32'h0, 1, 32'h80FF1234,
                  32'h100, 4'b1111, 32'h0, 32'hFFFF80FF);
    applyStimulus("lhu_zero",   1, 0, F3_LHU, 32'h102, 32'h0, 0, 32'h80FF1234,
                  32'h100, 4'b1111, 32'h0, 32'h000080FF);
    applyStimulus("lh_low",     1, 0, F3_LH,  32'h100, 32'h0, 0, 32'h80FF1234,
                  32'h100, 4'b1111, 32'h0, 32'h00001234);
    applyStimulus("sh_wait",    0, 1, F3_SH,  32'h202, 32'h0000ABCD, 3, 32'h0,
                  32'h200, 4'b1100, 32'hABCDABCD, 32'h0);
    applyStimulus("sb_lane1",   0, 1, F3_SB,  32'h301, 32'h123456A5, 0, 32'h0,
                  32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0);
    applyStimulus("ld_st_both", 1, 1, F3_SW,  32'h008, 32'h11223344, 0, 32'hFFFFFFFF,
                  32'h008, 4'b1111, 32'h11223344, 32'h0);

    applyIllegal("lw_misalign", 1, 0, F3_LW,  32'h101);
    applyIllegal("lh_odd",      1, 0, F3_LH,  32'h103);
    applyIllegal("ld_f3_011",   1, 0, 3'b011, 32'h000);
    applyIllegal("st_f3_100",   0, 1, 3'b100, 32'h000);
    applyIllegal("sw_misalign", 0, 1, F3_SW,  32'h006);

    // Reset while a load is in REQ; the late ack must be ignored.
    @(negedge clk);
    load = 1'b1; mem_write = 1'b0; funct3 = F3_LW; addr = 32'h400;
    @(negedge clk);
    #1;
    checkOutput("rstreq.req_before", {31'd0, mif.mem_req}, 32'd1);
    rst_n = 1'b0; load = 1'b0;
    #1;
    checkOutput("rstreq.stall_forced", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mif.mem_ack = 1'b1; mif.mem_rdata = 32'h12345678;
    #1;
    checkOutput("rstreq.req_after", {31'd0, mif.mem_req}, 32'd0);
    checkOutput("rstreq.addr_after", mif.mem_addr, 32'd0);
    checkOutput("rstreq.be_after", {28'd0, mif.mem_be}, 32'd0);
    checkOutput("rstreq.stall_after", {31'd0, stall}, 32'd0);
    @(negedge clk);
    mif.mem_ack = 1'b0;
    #1;
    checkOutput("rstreq.ack_ignored", {31'd0, ld_valid}, 32'd0);
    checkOutput("rstreq.req_idle", {31'd0, mif.mem_req}, 32'd0);
    checkOutput("rstreq.ld_data", ld_data, 32'd0);

    applyStimulus("lw_post_rst", 1, 0, F3_LW, 32'h104, 32'h0, 0, 32'hCAFEF00D,
                  32'h104, 4'b1111, 32'h0, 32'hCAFEF00D);

    checkOutput("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
